// File: rtl/ram_bist_ctrl.sv
// March-less RAM self-test: write pattern(a) = a ^ SEED to every word, read it back, count mismatches.
// Start-to-done latency 2*depth+1 cycles; no backpressure, abort/reset abandon the test immediately.
module ram_bist_ctrl #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_ce,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_first_err_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W:0]   ERR_MAX  = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ext;
        ext = '0;
        for (int i = 0; i < ADDR_W && i < DATA_W; i++) begin
            ext[i] = a[i];
        end
        return ext ^ SEED;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                cmp_vld_q;
    logic                cmp_vld_d;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic [ADDR_W-1:0]   cmp_addr_d;
    logic [ADDR_W:0]     err_cnt_q;
    logic [ADDR_W-1:0]   first_err_addr_q;
    logic                first_err_vld_q;
    logic                start_acc;
    logic                mismatch;

    // Read data lags the address by one cycle, so compares use the piped address.
    // The compare on an abort edge is dropped: the test is being abandoned.
    assign mismatch = cmp_vld_q && !i_abort && (i_rdata != pattern(cmp_addr_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmp_vld_d  = 1'b0;
        cmp_addr_d = cmp_addr_q;
        start_acc  = 1'b0;
        if (i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_d   = S_WRITE;
                        cnt_d     = '0;
                        start_acc = 1'b1;
                    end
                end
                S_WRITE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    cnt_d      = cnt_q + 1'b1;
                    cmp_vld_d  = 1'b1;
                    cmp_addr_d = cnt_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= cmp_addr_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
        end else if (start_acc) begin
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
        end else if (mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (!first_err_vld_q) begin
                first_err_addr_q <= cmp_addr_q;
                first_err_vld_q  <= 1'b1;
            end
        end
    end

    // RAM-side and status outputs are pure decodes of the registered state.
    always_comb begin
        o_ce    = 1'b0;
        o_we    = 1'b0;
        o_addr  = '0;
        o_wdata = '0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_pass  = 1'b0;
        case (state_q)
            S_WRITE: begin
                o_ce    = 1'b1;
                o_we    = 1'b1;
                o_addr  = cnt_q;
                o_wdata = pattern(cnt_q);
                o_busy  = 1'b1;
            end
            S_READ: begin
                o_ce   = 1'b1;
                o_addr = cnt_q;
                o_busy = 1'b1;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
                o_pass = (err_cnt_q == '0);
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_err_cnt        = err_cnt_q;
    assign o_first_err_addr = first_err_addr_q;
    assign o_first_err_vld  = first_err_vld_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with injectable read faults, timeline-based reference model,
// directed scenarios with literal expectations plus randomized start/abort traffic.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       o_ce, o_we, o_busy, o_done, o_pass, o_first_err_vld;
    logic [5:0] o_addr, o_first_err_addr;
    logic [7:0] o_wdata;
    logic [7:0] rdata = 8'h00;
    logic [6:0] o_err_cnt;

    int checks = 0;
    int errors = 0;

    ram_bist_ctrl #(.ADDR_W(6), .DATA_W(8), .SEED(8'hA5)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .o_ce(o_ce), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rdata(rdata), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
        .o_first_err_vld(o_first_err_vld)
    );

    initial forever #5 clk = ~clk;

    // RAM: registered read; read value = (stored & and_m) | or_m per address.
    logic [7:0] mem   [64];
    logic [7:0] and_m [64];
    logic [7:0] or_m  [64];
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (o_ce && o_we) begin
            mem[o_addr] <= o_wdata;
            wr_cnt      <= wr_cnt + 1;
        end
        if (o_ce && !o_we) begin
            rdata <= (mem[o_addr] & and_m[o_addr]) | or_m[o_addr];
        end
    end

    function automatic logic [7:0] pat(input logic [5:0] a);
        return {2'b00, a} ^ 8'hA5;
    endfunction

    function automatic bit faulty(input logic [5:0] a);
        logic [7:0] p;
        p = pat(a);
        return ((p & and_m[a]) | or_m[a]) != p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_t counts edges since the accepted start; writes at t=0..63 visible,
    // reads t=64..127, drain t=128, address a is judged at edge t=66+a, done at t=129.
    bit         m_run   = 1'b0;
    int         m_t     = 0;
    bit         m_done  = 1'b0;
    int         m_err   = 0;
    logic [5:0] m_first = 6'd0;
    bit         m_fvld  = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int a;
        if (rst) begin
            m_run <= 1'b0; m_t <= 0; m_done <= 1'b0;
            m_err <= 0; m_first <= 6'd0; m_fvld <= 1'b0;
        end else if (i_abort) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
        end else if (m_run) begin
            m_t <= m_t + 1;
            if (m_t + 1 >= 66) begin
                a = m_t + 1 - 66;
                if (faulty(a[5:0])) begin
                    m_err <= m_err + 1;
                    if (!m_fvld) begin
                        m_first <= a[5:0];
                        m_fvld  <= 1'b1;
                    end
                end
            end
            if (m_t + 1 == 129) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (i_start) begin
            m_run <= 1'b1; m_t <= 0; m_done <= 1'b0;
            m_err <= 0; m_first <= 6'd0; m_fvld <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic       e_ce, e_we;
        logic [5:0] e_addr;
        logic [7:0] e_wd;
        bit         chk_ram;
        if (!rst) begin
            e_ce = 1'b0; e_we = 1'b0; e_addr = 6'd0; e_wd = 8'd0; chk_ram = 1'b1;
            if (m_run) begin
                if (m_t < 64) begin
                    e_ce = 1'b1; e_we = 1'b1; e_addr = 6'(m_t); e_wd = pat(6'(m_t));
                end else if (m_t < 128) begin
                    e_ce = 1'b1; e_addr = 6'(m_t - 64);
                end else begin
                    chk_ram = 1'b0;
                end
            end
            chk("ce", 32'(o_ce), 32'(e_ce));
            chk("we", 32'(o_we), 32'(e_we));
            chk("busy", 32'(o_busy), 32'(m_run));
            if (chk_ram) begin
                chk("addr", 32'(o_addr), 32'(e_addr));
                chk("wdata", 32'(o_wdata), 32'(e_wd));
            end
            chk("done", 32'(o_done), 32'(m_done));
            chk("pass", 32'(o_pass), 32'(m_done && m_err == 0));
            chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
            chk("first_addr", 32'(o_first_err_addr), 32'(m_first));
            chk("first_vld", 32'(o_first_err_vld), 32'(m_fvld));
        end
    end

    // mode 0 good, 1 bit0 stuck-at-1 at 0x05/0x20, 2 reads all zero, 3 random faults
    task automatic set_mode(input int mode);
        for (int a = 0; a < 64; a++) begin
            and_m[a] = 8'hFF;
            or_m[a]  = 8'h00;
            if (mode == 2) and_m[a] = 8'h00;
            if (mode == 3 && $urandom_range(0, 7) == 0) begin
                and_m[a] = 8'($urandom);
                or_m[a]  = 8'($urandom);
            end
        end
        if (mode == 1) begin
            or_m[6'h05] = 8'h01;
            or_m[6'h20] = 8'h01;
        end
    endtask

    task automatic run_test(input string name, input int mode, input bit mid_start,
                            input int exp_err, input logic [5:0] exp_first);
        set_mode(mode);
        @(negedge clk); #2 i_start = 1'b1;
        @(negedge clk); #2 i_start = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            @(negedge clk); #2 i_start = mid_start && (i == 90);
        end
        chk({name, "_done_k128"}, 32'(o_done), 32'd0);
        @(negedge clk); #2;
        chk({name, "_done_k129"}, 32'(o_done), 32'd1);
        chk({name, "_pass"}, 32'(o_pass), 32'(exp_err == 0));
        chk({name, "_err"}, 32'(o_err_cnt), 32'(exp_err));
        chk({name, "_fvld"}, 32'(o_first_err_vld), 32'(exp_err != 0));
        if (exp_err != 0) chk({name, "_first"}, 32'(o_first_err_addr), 32'(exp_first));
    endtask

    initial begin : stim
        int w0;
        set_mode(0);
        #12;
        chk("rst_ce", 32'(o_ce), 0);           chk("rst_we", 32'(o_we), 0);
        chk("rst_addr", 32'(o_addr), 0);       chk("rst_wdata", 32'(o_wdata), 0);
        chk("rst_busy", 32'(o_busy), 0);       chk("rst_done", 32'(o_done), 0);
        chk("rst_pass", 32'(o_pass), 0);       chk("rst_err", 32'(o_err_cnt), 0);
        chk("rst_first", 32'(o_first_err_addr), 0);
        chk("rst_fvld", 32'(o_first_err_vld), 0);
        @(negedge clk); #2 rst = 1'b0;

        run_test("good", 0, 1'b0, 0, 6'd0);
        chk("mem_3f", 32'(mem[63]), 32'h9A);
        // pattern(0x20) = 0x85 already has bit 0 set, so only 0x05 reads back wrong
        run_test("stuck1", 1, 1'b0, 1, 6'h05);
        run_test("zeros", 2, 1'b0, 64, 6'h00);
        chk("zeros_err_bin", 32'(o_err_cnt), 32'b1000000);
        run_test("midstart", 0, 1'b1, 0, 6'd0);

        // abort in READ at address 0x10
        @(negedge clk); #2 i_start = 1'b1;
        @(negedge clk); #2 i_start = 1'b0;
        repeat (80) @(negedge clk);
        chk("abort_pre_addr", 32'(o_addr), 32'h10);
        chk("abort_pre_we", 32'(o_we), 0);
        #2 i_abort = 1'b1;
        @(negedge clk); #2 i_abort = 1'b0;
        chk("abort_ce", 32'(o_ce), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_done", 32'(o_done), 0);
        run_test("after_abort", 0, 1'b0, 0, 6'd0);

        // asynchronous reset in WRITE at cnt 0x22
        w0 = wr_cnt;
        @(negedge clk); #2 i_start = 1'b1;
        @(negedge clk); #2 i_start = 1'b0;
        repeat (34) @(negedge clk);
        chk("rstw_pre_addr", 32'(o_addr), 32'h22);
        #1 rst = 1'b1;
        #1;
        chk("rstw_ce", 32'(o_ce), 0);          chk("rstw_we", 32'(o_we), 0);
        chk("rstw_addr", 32'(o_addr), 0);      chk("rstw_wdata", 32'(o_wdata), 0);
        chk("rstw_busy", 32'(o_busy), 0);      chk("rstw_done", 32'(o_done), 0);
        chk("rstw_pass", 32'(o_pass), 0);      chk("rstw_err", 32'(o_err_cnt), 0);
        chk("rstw_first", 32'(o_first_err_addr), 0);
        chk("rstw_fvld", 32'(o_first_err_vld), 0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstw_writes", 32'(wr_cnt - w0), 32'h22);

        for (int ph = 0; ph < 2; ph++) begin
            set_mode(3);
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk); #2;
                i_start = ($urandom_range(0, 39) == 0);
                i_abort = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk); #2 i_start = 1'b0; i_abort = 1'b0;
            repeat (140) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
